sfp_norm_pipe: RTL and testbench
================================

# sfp_norm_pipe

Parametrised, handshaked successor to the core's combinational psum-sum / divide path. It accepts one row of `col` signed partial sums from psum memory. It forms the registered sum of magnitudes and optionally exchanges that sum with a peer core over a valid/ready channel. It then normalises each element through one shared serial divider and emits the normalised row through a valid/ready output stage. It sits between `psum_mem_instance` read data and the psum write-back mux, replacing the single-cycle `sfp_row` path.

## Interface
- `col`, 8, elements per row
- `bw_psum`, 20, signed psum width; also output element width
- `frac`, 8, fractional bits of quotient (dividend = |x| << frac)
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; one clock, sampled on rising edge
- `in_row`  in  col*bw_psum  element j at bits [bw_psum*(j+1)-1 : bw_psum*j]
- `in_valid` / `in_ready`  in / out  1  row handshake
- `ext_en`  in  1  sampled at row accept; 1 = combine with peer sum
- `signed_out`  in  1  sampled at row accept; 1 = restore input sign on output
- `sum_out`  out  bw_psum+4  local magnitude sum to peer
- `sum_out_valid` / `sum_out_ready`  out / in  1
- `sum_in`  in  bw_psum+4  peer magnitude sum
- `sum_in_valid` / `sum_in_ready`  in / out  1
- `out_row`  out  col*bw_psum  normalised row, same packing as `in_row`
- `out_valid` / `out_ready`  out / in  1
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, SUM, XCHG, DIV, OUT.
- IDLE
  - `in_ready`=1.
  - On `in_valid&in_ready`: capture row, `ext_en` and `signed_out`; go to SUM.
- SUM (1 cycle)
  - `sum_q` <= Σ|x_j|, bw_psum+4 bits.
  - |−2^(bw_psum−1)| = 2^(bw_psum−1), unsigned.
  - Next state: XCHG if `ext_en`, else DIV with total = `sum_q`.
- XCHG
  - `sum_out`=`sum_q` and `sum_out_valid`=1 until the `sum_out_ready` beat.
  - `sum_in_ready`=1 until the `sum_in_valid` beat.
  - The two handshakes are independent; both may complete in the same cycle, in either order, or across any stall.
  - Leave when both are done.
  - total = `sum_q` + `sum_in`, saturated to 2^(bw_psum+4)−1.
- DIV
  - Elements j=0..col−1 in order through the serial divider.
  - Divider: unsigned restoring; dividend (|x_j| << frac), width bw_psum+frac; divisor total; one quotient bit per cycle, D = bw_psum+frac cycles per element.
  - Quotient saturates to 2^(bw_psum−1)−1.
  - If `signed_out` and x_j<0, store −q; otherwise store q.
  - If total==0: no divide, every element stores 0, 1 cycle per element.
- OUT
  - `out_valid`=1; `out_row` is held stable until `out_ready`.
  - On the `out_ready` beat: go to IDLE.
- `in_ready`=0 in every state except IDLE; there is no overlap between rows.

## Timing
- Reset values: `in_ready`=1; `out_valid`, `sum_out_valid`, `sum_in_ready`, `busy`=0; `out_row`, `sum_out`=0.
- All outputs are registered except `in_ready`, which is decoded from state.
- Local mode: row accepted at edge t → `out_valid` high from cycle t+2+col·D.
  - Defaults: t+226.
  - Zero total: t+2+col.
- Ext mode: add the cycles spent in XCHG.
- Reset asserted in any state:
  - Next edge returns to IDLE and clears all outputs.
  - The partial row and any pending peer handshake are discarded.
  - The peer is not notified.
- `out_ready` held high before `out_valid`: the transfer completes in the first cycle `out_valid` is high.

## Structure
- Shared package `sfp_norm_pkg` holds:
  - state enum;
  - constants `SUM_BW = bw_psum+4` and `DIV_CYC = bw_psum+frac`;
  - an abs helper function.
- Sub-module `norm_div_serial`:
  - ports `start`/`done`, dividend, divisor, quotient;
  - owns the bit counter and the remainder register;
  - reset clears its state.

## Test plan
- Local mode, row all 1s, frac=8 → total 8; all outputs 32; `out_valid` at accept+226.
- `signed_out`=1, row {−4, 4, 0×6} → total 8; outputs {−128, 128, 0×6}; with `signed_out`=0 → {128, 128, 0×6}.
- `ext_en`, all-1s row, peer `sum_in`=8 presented 3 cycles before `sum_out_ready` (which stalls 5 cycles) → `sum_out`=8 held stable; total 16; outputs all 16.
- All-zero row → outputs all 0; `out_valid` at accept+2+col.
- `out_ready` low 10 cycles in OUT → `out_row` stable, `in_ready`=0, an `in_valid` row is not accepted until after the `out_ready` beat.
- `reset` mid-DIV → next cycle all outputs 0, `in_ready`=1, `busy`=0; the next all-1s row gives correct 32s.

Source files
------------

// File: rtl/sfp_norm_pkg.sv
// Shared state encoding, default sizing and helpers for the psum normalisation pipe.
package sfp_norm_pkg;

  localparam int COL_DEF     = 8;
  localparam int BW_PSUM_DEF = 20;
  localparam int FRAC_DEF    = 8;
  localparam int SUM_BW      = BW_PSUM_DEF + 4;
  localparam int DIV_CYC     = BW_PSUM_DEF + FRAC_DEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SUM,
    S_XCHG,
    S_DIV,
    S_OUT
  } state_e;

  // Magnitude of a sign-extended element; the most negative input maps to its unsigned magnitude.
  function automatic logic [31:0] abs_mag(input logic signed [31:0] v);
    return v[31] ? 32'(-v) : 32'(v);
  endfunction

endpackage

// File: rtl/norm_div_serial.sv
// Unsigned restoring divider producing one quotient bit per clock; the first bit is
// resolved on the start edge so a full quotient takes exactly DW clocks.
module norm_div_serial
  import sfp_norm_pkg::*;
#(
  parameter int DW = DIV_CYC,
  parameter int SW = SUM_BW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [SW-1:0] divisor,
  output logic          done,
  output logic [DW-1:0] quotient
);

  localparam int CW = $clog2(DW + 1);

  logic [SW-1:0] rem_q, rem_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [SW-1:0] dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [SW-1:0] step_rem_in;
  logic [SW-1:0] step_dvs;
  logic [SW:0]   trial;
  logic          step_bit;
  logic [SW-1:0] step_rem_out;

  // acc_q shifts dividend bits out of its MSB while quotient bits enter at the LSB.
  always_comb begin
    step_rem_in  = start ? '0 : rem_q;
    step_dvs     = start ? divisor : dvs_q;
    trial        = {step_rem_in, (start ? dividend[DW-1] : acc_q[DW-1])};
    step_bit     = (trial >= {1'b0, step_dvs});
    step_rem_out = step_bit ? SW'(trial - {1'b0, step_dvs}) : trial[SW-1:0];

    rem_d  = rem_q;
    acc_d  = acc_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;

    if (start) begin
      rem_d  = step_rem_out;
      acc_d  = {dividend[DW-2:0], step_bit};
      dvs_d  = divisor;
      cnt_d  = CW'(DW - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = step_rem_out;
      acc_d = {acc_q[DW-2:0], step_bit};
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      acc_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      acc_q  <= acc_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = acc_q;

endmodule

// File: rtl/sfp_norm_pipe.sv
// Handshaked row normaliser: sums element magnitudes, optionally merges a peer core's
// sum, then divides each element by the total through one shared serial divider.
module sfp_norm_pipe
  import sfp_norm_pkg::*;
#(
  parameter int col     = COL_DEF,
  parameter int bw_psum = BW_PSUM_DEF,
  parameter int frac    = FRAC_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*bw_psum-1:0] in_row,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   ext_en,
  input  logic                   signed_out,
  output logic [bw_psum+3:0]     sum_out,
  output logic                   sum_out_valid,
  input  logic                   sum_out_ready,
  input  logic [bw_psum+3:0]     sum_in,
  input  logic                   sum_in_valid,
  output logic                   sum_in_ready,
  output logic [col*bw_psum-1:0] out_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int SW = bw_psum + 4;
  localparam int DW = bw_psum + frac;
  localparam int IW = (col > 1) ? $clog2(col) : 1;
  localparam logic [bw_psum-1:0] QMAX = {1'b0, {(bw_psum-1){1'b1}}};

  state_e                 state_q, state_d;
  logic [col*bw_psum-1:0] row_q, row_d;
  logic                   ext_q, ext_d;
  logic                   sgn_q, sgn_d;
  logic [SW-1:0]          sum_q, sum_d;
  logic [SW-1:0]          total_q, total_d;
  logic [SW-1:0]          sum_out_q, sum_out_d;
  logic                   sum_out_valid_q, sum_out_valid_d;
  logic                   sum_in_ready_q, sum_in_ready_d;
  logic [SW-1:0]          peer_q, peer_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   inflight_q, inflight_d;
  logic                   zdone_q, zdone_d;
  logic [col*bw_psum-1:0] out_row_q, out_row_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;

  logic [SW-1:0]          mag_sum;
  logic [IW-1:0]          start_idx;
  logic [bw_psum-1:0]     start_mag;
  logic [DW-1:0]          div_dividend;
  logic                   div_start;
  logic                   div_done;
  logic [DW-1:0]          div_quot;
  logic                   cur_neg;
  logic [bw_psum-1:0]     q_sat;
  logic [bw_psum-1:0]     res_elem;
  logic                   launch;
  logic [SW:0]            ext_sum;

  // Datapath: magnitude sum, divider operand for the element being launched, and the result element.
  always_comb begin
    mag_sum = '0;
    for (int j = 0; j < col; j++) begin
      mag_sum = mag_sum + SW'(bw_psum'(abs_mag(32'(signed'(row_q[bw_psum*j +: bw_psum])))));
    end

    start_idx = idx_q;
    if (inflight_q && (idx_q != IW'(col - 1))) begin
      start_idx = IW'(idx_q + IW'(1));
    end
    start_mag    = bw_psum'(abs_mag(32'(signed'(row_q[bw_psum*start_idx +: bw_psum]))));
    div_dividend = {start_mag, {frac{1'b0}}};

    cur_neg  = row_q[bw_psum*idx_q + bw_psum - 1];
    q_sat    = '0;
    res_elem = '0;
    if (total_q != '0) begin
      q_sat    = (div_quot > DW'(QMAX)) ? QMAX : div_quot[bw_psum-1:0];
      res_elem = (sgn_q && cur_neg) ? (-q_sat) : q_sat;
    end
  end

  always_comb begin
    state_d         = state_q;
    row_d           = row_q;
    ext_d           = ext_q;
    sgn_d           = sgn_q;
    sum_d           = sum_q;
    total_d         = total_q;
    sum_out_d       = sum_out_q;
    sum_out_valid_d = sum_out_valid_q;
    sum_in_ready_d  = sum_in_ready_q;
    peer_d          = peer_q;
    idx_d           = idx_q;
    inflight_d      = inflight_q;
    zdone_d         = 1'b0;
    out_row_d       = out_row_q;
    out_valid_d     = out_valid_q;
    div_start       = 1'b0;
    launch          = 1'b0;
    ext_sum         = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          row_d   = in_row;
          ext_d   = ext_en;
          sgn_d   = signed_out;
          state_d = S_SUM;
        end
      end

      S_SUM: begin
        sum_d      = mag_sum;
        idx_d      = '0;
        inflight_d = 1'b0;
        if (ext_q) begin
          sum_out_d       = mag_sum;
          sum_out_valid_d = 1'b1;
          sum_in_ready_d  = 1'b1;
          state_d         = S_XCHG;
        end else begin
          total_d = mag_sum;
          state_d = S_DIV;
        end
      end

      // Each side of the exchange retires on its own beat; leave once both have retired.
      S_XCHG: begin
        if (sum_out_valid_q && sum_out_ready) begin
          sum_out_valid_d = 1'b0;
        end
        if (sum_in_ready_q && sum_in_valid) begin
          sum_in_ready_d = 1'b0;
          peer_d         = sum_in;
        end
        ext_sum = {1'b0, sum_q} + {1'b0, peer_d};
        if (!sum_out_valid_d && !sum_in_ready_d) begin
          total_d = ext_sum[SW] ? '1 : ext_sum[SW-1:0];
          state_d = S_DIV;
        end
      end

      // A zero total skips the divider and spends one cycle per element on a stored zero.
      S_DIV: begin
        if (!inflight_q) begin
          launch = 1'b1;
        end else if (div_done || zdone_q) begin
          out_row_d[bw_psum*idx_q +: bw_psum] = res_elem;
          if (idx_q == IW'(col - 1)) begin
            inflight_d  = 1'b0;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
          end else begin
            idx_d  = IW'(idx_q + IW'(1));
            launch = 1'b1;
          end
        end
        if (launch) begin
          inflight_d = 1'b1;
          if (total_q == '0) begin
            zdone_d = 1'b1;
          end else begin
            div_start = 1'b1;
          end
        end
      end

      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      row_q           <= '0;
      ext_q           <= 1'b0;
      sgn_q           <= 1'b0;
      sum_q           <= '0;
      total_q         <= '0;
      sum_out_q       <= '0;
      sum_out_valid_q <= 1'b0;
      sum_in_ready_q  <= 1'b0;
      peer_q          <= '0;
      idx_q           <= '0;
      inflight_q      <= 1'b0;
      zdone_q         <= 1'b0;
      out_row_q       <= '0;
      out_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      ext_q           <= ext_d;
      sgn_q           <= sgn_d;
      sum_q           <= sum_d;
      total_q         <= total_d;
      sum_out_q       <= sum_out_d;
      sum_out_valid_q <= sum_out_valid_d;
      sum_in_ready_q  <= sum_in_ready_d;
      peer_q          <= peer_d;
      idx_q           <= idx_d;
      inflight_q      <= inflight_d;
      zdone_q         <= zdone_d;
      out_row_q       <= out_row_d;
      out_valid_q     <= out_valid_d;
      busy_q          <= busy_d;
    end
  end

  norm_div_serial #(
    .DW(DW),
    .SW(SW)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (total_q),
    .done     (div_done),
    .quotient (div_quot)
  );

  assign in_ready      = (state_q == S_IDLE);
  assign sum_out       = sum_out_q;
  assign sum_out_valid = sum_out_valid_q;
  assign sum_in_ready  = sum_in_ready_q;
  assign out_row       = out_row_q;
  assign out_valid     = out_valid_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_sfp_norm_pipe.sv
// Self-checking bench for sfp_norm_pipe: directed scenarios plus randomized rows
// compared against an integer-arithmetic reference of the normalisation.
module tb_sfp_norm_pipe;

  localparam int COL  = 8;
  localparam int BW   = 20;
  localparam int FRAC = 8;
  localparam int SW   = BW + 4;
  localparam int D    = BW + FRAC;

  typedef int row_t[COL];

  logic                clk = 1'b0;
  logic                reset;
  logic [COL*BW-1:0]   in_row;
  logic                in_valid, in_ready, ext_en, signed_out;
  logic [SW-1:0]       sum_out, sum_in;
  logic                sum_out_valid, sum_out_ready, sum_in_valid, sum_in_ready;
  logic [COL*BW-1:0]   out_row;
  logic                out_valid, out_ready, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_acc = 0;

  sfp_norm_pipe #(.col(COL), .bw_psum(BW), .frac(FRAC)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_row        (in_row),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ext_en        (ext_en),
    .signed_out    (signed_out),
    .sum_out       (sum_out),
    .sum_out_valid (sum_out_valid),
    .sum_out_ready (sum_out_ready),
    .sum_in        (sum_in),
    .sum_in_valid  (sum_in_valid),
    .sum_in_ready  (sum_in_ready),
    .out_row       (out_row),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [COL*BW-1:0] pack(input row_t x);
    logic [COL*BW-1:0] r;
    for (int j = 0; j < COL; j++) r[BW*j +: BW] = BW'(x[j]);
    return r;
  endfunction

  function automatic longint mag_total(input row_t x);
    longint s = 0;
    for (int j = 0; j < COL; j++) s += (x[j] < 0) ? -longint'(x[j]) : longint'(x[j]);
    return s;
  endfunction

  // Reference: q = floor(|x| * 2^frac / total), clipped to the largest positive element, sign optional.
  function automatic logic [COL*BW-1:0] model_row(input row_t x, input longint total, input bit so);
    logic [COL*BW-1:0] r;
    longint m, q;
    for (int j = 0; j < COL; j++) begin
      m = (x[j] < 0) ? -longint'(x[j]) : longint'(x[j]);
      q = (total == 0) ? 0 : (m * (longint'(1) << FRAC)) / total;
      if (q > (longint'(1) << (BW - 1)) - 1) q = (longint'(1) << (BW - 1)) - 1;
      if (so && x[j] < 0) q = -q;
      r[BW*j +: BW] = BW'(q);
    end
    return r;
  endfunction

  function automatic longint ext_total(input longint s, input longint peer);
    longint t = s + peer;
    if (t > (longint'(1) << SW) - 1) t = (longint'(1) << SW) - 1;
    return t;
  endfunction

  task automatic send_row(input row_t x, input bit ext, input bit so, output bit ok);
    in_row = pack(x);
    ext_en = ext;
    signed_out = so;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    t_acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output bit ok);
    ok = 1'b0;
    lat = -1;
    for (int k = 0; k < 3000 && !ok; k++) begin
      if (out_valid) begin
        ok = 1'b1;
        lat = cyc - t_acc;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_xchg(input logic [SW-1:0] peer, input int in_dly, input int out_dly,
                         output bit ok, output logic [SW-1:0] first, output int changes);
    bit in_done = 1'b0, out_done = 1'b0, in_fire, out_fire;
    changes = 0;
    for (int w = 0; w < 50 && !sum_out_valid; w++) begin
      @(posedge clk); #1;
    end
    first = sum_out;
    for (int k = 0; k < 60 && !(in_done && out_done); k++) begin
      if (k == in_dly) begin
        sum_in = peer;
        sum_in_valid = 1'b1;
      end
      if (k == out_dly) sum_out_ready = 1'b1;
      if (sum_out_valid && sum_out !== first) changes++;
      in_fire  = sum_in_valid && sum_in_ready;
      out_fire = sum_out_valid && sum_out_ready;
      @(posedge clk); #1;
      if (in_fire) begin
        sum_in_valid = 1'b0;
        in_done = 1'b1;
      end
      if (out_fire) begin
        sum_out_ready = 1'b0;
        out_done = 1'b1;
      end
    end
    ok = in_done && out_done;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    got = {in_ready, out_valid, sum_out_valid, sum_in_ready, busy, |out_row, |sum_out};
    checks++;
    if (got !== 7'b1000000) begin
      errors++;
      $display("[TB] FAIL reset_state got %b exp %b", got, 7'b1000000);
    end
  endtask

  task automatic test_local_ones();
    row_t x;
    bit ok;
    int lat;
    logic [COL*BW-1:0] exp_row;
    for (int j = 0; j < COL; j++) x[j] = 1;
    exp_row = model_row(x, mag_total(x), 1'b0);
    send_row(x, 1'b0, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL ones_accept got timeout exp accept"); end
    checks++;
    if ({busy, in_ready} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL ones_busy got %b exp %b", {busy, in_ready}, 2'b10);
    end
    wait_out(lat, ok);
    checks++;
    if (lat != 2 + COL * D) begin errors++; $display("[TB] FAIL ones_latency got %0d exp %0d", lat, 2 + COL * D); end
    checks++;
    if (out_row !== exp_row) begin errors++; $display("[TB] FAIL ones_row got %h exp %h", out_row, exp_row); end
    take_out();
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL ones_release got %b exp %b", {out_valid, in_ready, busy}, 3'b010);
    end
  endtask

  task automatic test_signed();
    row_t x;
    bit ok;
    int lat;
    logic [COL*BW-1:0] exp_row;
    for (int j = 0; j < COL; j++) x[j] = 0;
    x[0] = -4;
    x[1] = 4;
    for (int s = 1; s >= 0; s--) begin
      exp_row = model_row(x, mag_total(x), s[0]);
      send_row(x, 1'b0, s[0], ok);
      wait_out(lat, ok);
      checks++;
      if (!ok || out_row !== exp_row) begin
        errors++;
        $display("[TB] FAIL signed_row so=%0d got %h exp %h", s, out_row, exp_row);
      end
      take_out();
    end
    x[0] = -(1 << (BW - 1));
    x[1] = 0;
    exp_row = model_row(x, mag_total(x), 1'b1);
    send_row(x, 1'b0, 1'b1, ok);
    wait_out(lat, ok);
    checks++;
    if (!ok || out_row !== exp_row) begin
      errors++;
      $display("[TB] FAIL most_negative got %h exp %h", out_row, exp_row);
    end
    take_out();
  endtask

  task automatic test_zero();
    row_t x;
    bit ok;
    int lat;
    for (int j = 0; j < COL; j++) x[j] = 0;
    send_row(x, 1'b0, 1'b1, ok);
    wait_out(lat, ok);
    checks++;
    if (lat != 2 + COL) begin errors++; $display("[TB] FAIL zero_latency got %0d exp %0d", lat, 2 + COL); end
    checks++;
    if (out_row !== '0) begin errors++; $display("[TB] FAIL zero_row got %h exp 0", out_row); end
    take_out();
  endtask

  task automatic test_ext();
    row_t x;
    bit ok;
    int lat, changes;
    logic [SW-1:0] first;
    logic [COL*BW-1:0] exp_row;
    for (int j = 0; j < COL; j++) x[j] = 1;
    exp_row = model_row(x, ext_total(mag_total(x), 8), 1'b0);
    send_row(x, 1'b1, 1'b0, ok);
    do_xchg(SW'(8), 2, 5, ok, first, changes);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL ext_handshake got timeout exp both beats"); end
    checks++;
    if (first !== SW'(mag_total(x)) || changes != 0) begin
      errors++;
      $display("[TB] FAIL ext_sum_out got %0d (changes %0d) exp %0d", first, changes, mag_total(x));
    end
    checks++;
    if ({sum_out_valid, sum_in_ready, in_ready} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL ext_handshake_drop got %b exp 000", {sum_out_valid, sum_in_ready, in_ready});
    end
    wait_out(lat, ok);
    checks++;
    if (!ok || out_row !== exp_row) begin errors++; $display("[TB] FAIL ext_row got %h exp %h", out_row, exp_row); end
    take_out();
  endtask

  task automatic test_random();
    row_t x;
    bit ok, ext, so;
    int lat, changes, exp_lat;
    longint tot;
    logic [SW-1:0] peer, first;
    logic [COL*BW-1:0] exp_row;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < COL; j++) begin
        case ($urandom_range(0, 3))
          0: x[j] = int'($urandom_range(0, 16)) - 8;
          1: x[j] = int'($urandom_range(0, (1 << BW) - 1)) - (1 << (BW - 1));
          2: x[j] = 0;
          default: x[j] = ($urandom_range(0, 1) != 0) ? -(1 << (BW - 1)) : (1 << (BW - 1)) - 1;
        endcase
      end
      ext = i[0];
      so = ($urandom_range(0, 1) != 0);
      peer = ($urandom_range(0, 2) == 0) ? '1 : SW'($urandom_range(0, 1 << 22));
      tot = ext ? ext_total(mag_total(x), longint'(peer)) : mag_total(x);
      exp_row = model_row(x, tot, so);
      send_row(x, ext, so, ok);
      if (ext) begin
        do_xchg(peer, $urandom_range(0, 4), $urandom_range(0, 4), ok, first, changes);
        checks++;
        if (!ok || first !== SW'(mag_total(x))) begin
          errors++;
          $display("[TB] FAIL rand_sum_out[%0d] got %0d exp %0d", i, first, mag_total(x));
        end
      end
      wait_out(lat, ok);
      checks++;
      if (!ok || out_row !== exp_row) begin
        errors++;
        $display("[TB] FAIL rand_row[%0d] got %h exp %h", i, out_row, exp_row);
      end
      if (!ext) begin
        exp_lat = (tot == 0) ? 2 + COL : 2 + COL * D;
        checks++;
        if (lat != exp_lat) begin errors++; $display("[TB] FAIL rand_latency[%0d] got %0d exp %0d", i, lat, exp_lat); end
      end
      take_out();
    end
  endtask

  task automatic test_out_stall();
    row_t x, y;
    bit ok;
    int lat, bad;
    logic [COL*BW-1:0] exp_row, exp_y;
    for (int j = 0; j < COL; j++) begin
      x[j] = 1;
      y[j] = 0;
    end
    y[0] = -4;
    y[1] = 4;
    exp_row = model_row(x, mag_total(x), 1'b0);
    exp_y   = model_row(y, mag_total(y), 1'b1);
    send_row(x, 1'b0, 1'b0, ok);
    wait_out(lat, ok);
    in_row = pack(y);
    signed_out = 1'b1;
    in_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_row !== exp_row || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL stall_hold got %0d bad cycles exp 0", bad); end
    take_out();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL stall_release got %b exp 01", {out_valid, in_ready});
    end
    send_row(y, 1'b0, 1'b1, ok);
    wait_out(lat, ok);
    checks++;
    if (!ok || out_row !== exp_y) begin errors++; $display("[TB] FAIL stall_next_row got %h exp %h", out_row, exp_y); end
    take_out();
  endtask

  task automatic test_reset_mid_div();
    row_t x;
    bit ok;
    int lat, spur;
    logic [6:0] got;
    logic [COL*BW-1:0] exp_row;
    for (int j = 0; j < COL; j++) x[j] = 1;
    exp_row = model_row(x, mag_total(x), 1'b0);
    send_row(x, 1'b0, 1'b0, ok);
    repeat (50) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    got = {in_ready, out_valid, sum_out_valid, sum_in_ready, busy, |out_row, |sum_out};
    checks++;
    if (got !== 7'b1000000) begin
      errors++;
      $display("[TB] FAIL reset_mid_div got %b exp %b", got, 7'b1000000);
    end
    spur = 0;
    for (int k = 0; k < 250; k++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) spur++;
      @(posedge clk); #1;
    end
    checks++;
    if (spur != 0) begin errors++; $display("[TB] FAIL reset_quiet got %0d active cycles exp 0", spur); end
    send_row(x, 1'b0, 1'b0, ok);
    wait_out(lat, ok);
    checks++;
    if (!ok || out_row !== exp_row || lat != 2 + COL * D) begin
      errors++;
      $display("[TB] FAIL reset_recover got %h lat %0d exp %h lat %0d", out_row, lat, exp_row, 2 + COL * D);
    end
    take_out();
  endtask

  initial begin
    reset = 1'b1;
    in_row = '0;
    in_valid = 1'b0;
    ext_en = 1'b0;
    signed_out = 1'b0;
    sum_out_ready = 1'b0;
    sum_in = '0;
    sum_in_valid = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_local_ones();
    test_signed();
    test_zero();
    test_ext();
    test_random();
    test_out_stall();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
